// File: rtl/fetch_sequencer.sv
// Purpose : instruction-fetch control FSM (PC->MAR, timed memory read into MDR, MDR->IR, pause for Continue).
// Latency : strobes are registered Moore outputs of the current state; ld_ir rises MEM_WAIT+2 cycles after S18 entry.
// Backpr. : none on the datapath side; the sequence advances only on run_i (HALTED) and continue_i (PAUSE_IR1/2).
//
// Ports:
//   clk, reset          sole clock (rising edge) and asynchronous active-high reset
//   run_i, continue_i   debounced Run / Continue button levels
//   ld_mar .. ld_led    datapath register load enables
//   gate_pc, gate_mdr   bus drivers (mutually exclusive by construction)
//   pcmux               PC source select, 2'b00 = PC+1
//   mem_mem_ena         memory enable; mem_wr_ena is tied low (reads only)
//   state_o, halted_o   debug state encoding and HALTED flag
//
// MEM_WAIT must lie in 1..15: the wait counter is 4 bits wide and holds MEM_WAIT-1.

module fetch_sequencer #(
    parameter int unsigned MEM_WAIT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_i,
    input  logic       continue_i,
    output logic       ld_mar,
    output logic       ld_mdr,
    output logic       ld_ir,
    output logic       ld_pc,
    output logic       ld_led,
    output logic       gate_pc,
    output logic       gate_mdr,
    output logic [1:0] pcmux,
    output logic       mem_mem_ena,
    output logic       mem_wr_ena,
    output logic [3:0] state_o,
    output logic       halted_o
);

    typedef enum logic [2:0] {
        HALTED    = 3'd0,
        S18       = 3'd1,
        S33_1     = 3'd2,
        S33_2     = 3'd3,
        S35       = 3'd4,
        PAUSE_IR1 = 3'd5,
        PAUSE_IR2 = 3'd6
    } state_t;

    // All control strobes travel together so they can be registered as one word.
    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_pc;
        logic       ld_led;
        logic       gate_pc;
        logic       gate_mdr;
        logic [1:0] pcmux;
        logic       mem_mem_ena;
        logic       mem_wr_ena;
        logic       halted;
    } ctrl_t;

    // Value loaded on entry to S33_1; the state is held until the counter reaches 0,
    // so S33_1 lasts exactly MEM_WAIT cycles.
    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);

    state_t     state_q, state_d;
    logic [3:0] wait_q,  wait_d;
    ctrl_t      ctrl_q,  ctrl_d;

    // Moore decode of the strobes for a given state. The unused encoding decodes
    // to all-zero (halted_o is high only in HALTED itself).
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            HALTED: begin
                c.halted = 1'b1;
            end
            S18: begin
                c.gate_pc = 1'b1;
                c.ld_mar  = 1'b1;
                c.ld_pc   = 1'b1;
                c.pcmux   = 2'b00;
            end
            S33_1: begin
                c.mem_mem_ena = 1'b1;
            end
            S33_2: begin
                c.mem_mem_ena = 1'b1;
                c.ld_mdr      = 1'b1;
            end
            S35: begin
                c.gate_mdr = 1'b1;
                c.ld_ir    = 1'b1;
            end
            PAUSE_IR1: begin
                c.ld_led = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            HALTED: begin
                // run_i wins over continue_i here; continue_i is not looked at.
                if (run_i) begin
                    state_d = S18;
                end
            end
            S18: begin
                state_d = S33_1;
                wait_d  = WAIT_INIT;
            end
            S33_1: begin
                if (wait_q == 4'd0) begin
                    state_d = S33_2;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S33_2: begin
                state_d = S35;
            end
            S35: begin
                state_d = PAUSE_IR1;
            end
            PAUSE_IR1: begin
                if (continue_i) begin
                    state_d = PAUSE_IR2;
                end
            end
            PAUSE_IR2: begin
                // Wait for the button to be released so one press gives one fetch.
                if (!continue_i) begin
                    state_d = S18;
                end
            end
            default: begin
                state_d = HALTED;
                wait_d  = 4'd0;
            end
        endcase
        // Outputs are registered from the next state so they line up with state_q
        // while still being flop outputs.
        ctrl_d = decode_ctrl(state_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HALTED;
            wait_q  <= 4'd0;
            ctrl_q  <= decode_ctrl(HALTED);
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign ld_mar      = ctrl_q.ld_mar;
    assign ld_mdr      = ctrl_q.ld_mdr;
    assign ld_ir       = ctrl_q.ld_ir;
    assign ld_pc       = ctrl_q.ld_pc;
    assign ld_led      = ctrl_q.ld_led;
    assign gate_pc     = ctrl_q.gate_pc;
    assign gate_mdr    = ctrl_q.gate_mdr;
    assign pcmux       = ctrl_q.pcmux;
    assign mem_mem_ena = ctrl_q.mem_mem_ena;
    assign mem_wr_ena  = ctrl_q.mem_wr_ena;
    assign halted_o    = ctrl_q.halted;
    assign state_o     = {1'b0, state_q};

endmodule

// File: tb/tb_fetch_sequencer.sv
// Purpose : directed bench for fetch_sequencer, two instances (MEM_WAIT=3 and MEM_WAIT=1) sharing stimulus.
// Latency : outputs sampled 1 time unit after each rising edge, or mid-cycle for the async reset case.
// Backpr. : none; every scenario runs a fixed number of cycles.

module tb_fetch_sequencer;

    logic clk;
    logic reset;
    logic run_i;
    logic continue_i;

    logic       a_ld_mar, a_ld_mdr, a_ld_ir, a_ld_pc, a_ld_led, a_gate_pc, a_gate_mdr;
    logic [1:0] a_pcmux;
    logic       a_mem_ena, a_wr_ena, a_halted;
    logic [3:0] a_state;

    logic       b_ld_mar, b_ld_mdr, b_ld_ir, b_ld_pc, b_ld_led, b_gate_pc, b_gate_mdr;
    logic [1:0] b_pcmux;
    logic       b_mem_ena, b_wr_ena, b_halted;
    logic [3:0] b_state;

    int vectors;
    int miscompares;

    // Expected strobe word per state, hand-written:
    // {ld_mar, ld_mdr, ld_ir, ld_pc, ld_led, gate_pc, gate_mdr, mem_mem_ena, mem_wr_ena, halted_o}
    logic [9:0] exp_out [0:6];

    fetch_sequencer #(.MEM_WAIT(3)) u_dut3 (
        .clk(clk), .reset(reset), .run_i(run_i), .continue_i(continue_i),
        .ld_mar(a_ld_mar), .ld_mdr(a_ld_mdr), .ld_ir(a_ld_ir), .ld_pc(a_ld_pc), .ld_led(a_ld_led),
        .gate_pc(a_gate_pc), .gate_mdr(a_gate_mdr), .pcmux(a_pcmux),
        .mem_mem_ena(a_mem_ena), .mem_wr_ena(a_wr_ena), .state_o(a_state), .halted_o(a_halted)
    );

    fetch_sequencer #(.MEM_WAIT(1)) u_dut1 (
        .clk(clk), .reset(reset), .run_i(run_i), .continue_i(continue_i),
        .ld_mar(b_ld_mar), .ld_mdr(b_ld_mdr), .ld_ir(b_ld_ir), .ld_pc(b_ld_pc), .ld_led(b_ld_led),
        .gate_pc(b_gate_pc), .gate_mdr(b_gate_mdr), .pcmux(b_pcmux),
        .mem_mem_ena(b_mem_ena), .mem_wr_ena(b_wr_ena), .state_o(b_state), .halted_o(b_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] obs_a();
        return {a_ld_mar, a_ld_mdr, a_ld_ir, a_ld_pc, a_ld_led, a_gate_pc, a_gate_mdr, a_mem_ena, a_wr_ena, a_halted};
    endfunction

    function automatic logic [9:0] obs_b();
        return {b_ld_mar, b_ld_mdr, b_ld_ir, b_ld_pc, b_ld_led, b_gate_pc, b_gate_mdr, b_mem_ena, b_wr_ena, b_halted};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Before any clock edge, reset alone must force HALTED.
        #2;
        vectors++;
        if (a_state !== 4'd0 || obs_a() !== 10'b0000000001 || a_pcmux !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_no_clk: state=%0d out=%b pcmux=%b, want state=0 out=0000000001 pcmux=00",
                     a_state, obs_a(), a_pcmux);
        end
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (a_state !== 4'd0 || b_state !== 4'd0 || a_halted !== 1'b1) begin
                miscompares++;
                $display("FAIL idle_after_reset[%0d]: state3=%0d state1=%0d halted=%b, want 0 0 1",
                         i, a_state, b_state, a_halted);
            end
        end
    endtask

    task automatic test_fetch();
        int seq [0:5];
        int ir_at;
        seq = '{2, 2, 2, 3, 4, 5};
        ir_at = -1;
        run_i = 1'b1;
        step();
        run_i = 1'b0;
        vectors++;
        if (a_state !== 4'd1 || obs_a() !== exp_out[1] || a_pcmux !== 2'b00) begin
            miscompares++;
            $display("FAIL fetch_s18: state=%0d out=%b pcmux=%b, want state=1 out=%b pcmux=00",
                     a_state, obs_a(), a_pcmux, exp_out[1]);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            if (a_ld_ir === 1'b1 && ir_at < 0) ir_at = i + 1;
            vectors++;
            if (a_state !== 4'(seq[i]) || obs_a() !== exp_out[seq[i]]) begin
                miscompares++;
                $display("FAIL fetch_seq[%0d]: state=%0d out=%b, want state=%0d out=%b",
                         i, a_state, obs_a(), seq[i], exp_out[seq[i]]);
            end
        end
        vectors++;
        if (ir_at !== 5) begin
            miscompares++;
            $display("FAIL fetch_ld_ir_latency: got %0d cycles, want 5", ir_at);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (a_state !== 4'd5 || obs_a() !== exp_out[5]) begin
                miscompares++;
                $display("FAIL fetch_pause_hold[%0d]: state=%0d out=%b, want state=5 out=%b",
                         i, a_state, obs_a(), exp_out[5]);
            end
        end
    endtask

    task automatic test_continue();
        int pc_pulses;
        pc_pulses = 0;
        continue_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (a_ld_pc === 1'b1) pc_pulses++;
            vectors++;
            if (a_state !== 4'd6 || obs_a() !== exp_out[6]) begin
                miscompares++;
                $display("FAIL continue_held[%0d]: state=%0d out=%b, want state=6 out=%b",
                         i, a_state, obs_a(), exp_out[6]);
            end
        end
        continue_i = 1'b0;
        step();
        if (a_ld_pc === 1'b1) pc_pulses++;
        vectors++;
        if (a_state !== 4'd1) begin
            miscompares++;
            $display("FAIL continue_release: state=%0d, want 1", a_state);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            if (a_ld_pc === 1'b1) pc_pulses++;
        end
        vectors++;
        if (pc_pulses !== 1 || a_state !== 4'd5) begin
            miscompares++;
            $display("FAIL continue_one_fetch: ld_pc pulses=%0d state=%0d, want 1 pulse state=5",
                     pc_pulses, a_state);
        end
    endtask

    task automatic test_abort();
        int mdr_pulses;
        mdr_pulses = 0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        run_i = 1'b1;
        step();
        run_i = 1'b0;
        step();
        step();
        vectors++;
        if (a_state !== 4'd2) begin
            miscompares++;
            $display("FAIL abort_setup: state=%0d, want 2 (second S33_1 cycle)", a_state);
        end
        // Mid-cycle: next rising edge is 9 time units away.
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (a_state !== 4'd0 || obs_a() !== 10'b0000000001 || a_pcmux !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_async: state=%0d out=%b pcmux=%b, want state=0 out=0000000001 pcmux=00",
                     a_state, obs_a(), a_pcmux);
        end
        step();
        if (a_ld_mdr === 1'b1) mdr_pulses++;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (a_ld_mdr === 1'b1) mdr_pulses++;
        end
        vectors++;
        if (mdr_pulses !== 0 || a_state !== 4'd0) begin
            miscompares++;
            $display("FAIL abort_no_mdr: ld_mdr pulses=%0d state=%0d, want 0 pulses state=0",
                     mdr_pulses, a_state);
        end
    endtask

    task automatic test_mem_wait1();
        int seq [0:3];
        seq = '{2, 3, 4, 5};
        run_i = 1'b1;
        step();
        run_i = 1'b0;
        vectors++;
        if (b_state !== 4'd1 || obs_b() !== exp_out[1]) begin
            miscompares++;
            $display("FAIL mw1_s18: state=%0d out=%b, want state=1 out=%b", b_state, obs_b(), exp_out[1]);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (b_state !== 4'(seq[i]) || obs_b() !== exp_out[seq[i]]) begin
                miscompares++;
                $display("FAIL mw1_seq[%0d]: state=%0d out=%b, want state=%0d out=%b",
                         i, b_state, obs_b(), seq[i], exp_out[seq[i]]);
            end
        end
    endtask

    task automatic test_run_through_reset();
        int seq [0:6];
        seq = '{2, 2, 2, 3, 4, 5, 6};
        reset = 1'b1;
        run_i = 1'b1;
        continue_i = 1'b1;
        step();
        step();
        vectors++;
        if (a_state !== 4'd0 || a_halted !== 1'b1) begin
            miscompares++;
            $display("FAIL rtr_in_reset: state=%0d halted=%b, want 0 1", a_state, a_halted);
        end
        reset = 1'b0;
        step();
        vectors++;
        if (a_state !== 4'd1) begin
            miscompares++;
            $display("FAIL rtr_first_edge: state=%0d, want 1", a_state);
        end
        // run_i and continue_i stay high: both must be ignored until PAUSE_IR1.
        for (int i = 0; i < 7; i++) begin
            step();
            vectors++;
            if (a_state !== 4'(seq[i])) begin
                miscompares++;
                $display("FAIL rtr_seq[%0d]: state=%0d, want %0d", i, a_state, seq[i]);
            end
        end
        run_i = 1'b0;
        continue_i = 1'b0;
        step();
        vectors++;
        if (a_state !== 4'd1) begin
            miscompares++;
            $display("FAIL rtr_release: state=%0d, want 1", a_state);
        end
    endtask

    task automatic test_random();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            run_i = ($urandom_range(0, 3) == 0);
            continue_i = ($urandom_range(0, 1) == 1);
            step();
            vectors++;
            if (a_wr_ena !== 1'b0 || b_wr_ena !== 1'b0) begin
                miscompares++;
                $display("FAIL rnd_wr_ena[%0d]: got %b/%b, want 0/0", i, a_wr_ena, b_wr_ena);
            end
            vectors++;
            if ((a_gate_pc & a_gate_mdr) !== 1'b0 || (b_gate_pc & b_gate_mdr) !== 1'b0) begin
                miscompares++;
                $display("FAIL rnd_gate_excl[%0d]: got %b%b/%b%b, want not both", i,
                         a_gate_pc, a_gate_mdr, b_gate_pc, b_gate_mdr);
            end
            vectors++;
            if ((a_ld_mar & a_ld_mdr) !== 1'b0 || (b_ld_mar & b_ld_mdr) !== 1'b0) begin
                miscompares++;
                $display("FAIL rnd_mar_mdr[%0d]: got %b%b/%b%b, want not both", i,
                         a_ld_mar, a_ld_mdr, b_ld_mar, b_ld_mdr);
            end
            vectors++;
            if (a_state > 4'd6 || b_state > 4'd6 || $isunknown(a_state) || $isunknown(b_state)) begin
                miscompares++;
                $display("FAIL rnd_state[%0d]: got %0d/%0d, want 0..6", i, a_state, b_state);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        exp_out[0] = 10'b0000000001;
        exp_out[1] = 10'b1001010000;
        exp_out[2] = 10'b0000000100;
        exp_out[3] = 10'b0100000100;
        exp_out[4] = 10'b0010001000;
        exp_out[5] = 10'b0000100000;
        exp_out[6] = 10'b0000000000;
        reset = 1'b1;
        run_i = 1'b0;
        continue_i = 1'b0;

        test_reset();
        test_fetch();
        test_continue();
        test_abort();
        test_mem_wait1();
        test_run_through_reset();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
